uart_rx_word_packer: RTL and testbench

Receive-side companion to the RAM-to-UART block transmitter: takes bytes from the `uart_rx` core and packs them little-endian into 32-bit words. Each word is written into the shared dual-port log RAM at an incrementing word address, and an idle timer flushes partially filled words. It sits between `uart_rx` and the RAM write port. It also publishes a byte count and overflow status for return over the JTAG state register.

---
 rtl/uart_rx_word_packer.sv | 131 +++++++++++++
 tb/tb_uart_rx_word_packer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_word_packer.sv
// Packs received UART bytes little-endian into 32-bit words and writes each update
// to the shared log RAM; an idle timer rewrites a partially filled word once.
module uart_rx_word_packer #(
    parameter int unsigned ADDR_W       = 11,
    parameter int unsigned IDLE_TIMEOUT = 26042
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W+2:0] byte_count,
    output logic              full,
    output logic              overflow
);

    localparam int unsigned BC_W  = ADDR_W + 3;
    localparam int unsigned TMR_W = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [BC_W-1:0]  CAPACITY = BC_W'(1) << (ADDR_W + 2);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(IDLE_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_DONE = TMR_W'(IDLE_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } state_e;

    state_e            state_q;
    logic              rx_valid_q;
    logic              rx_valid_qq;
    logic [7:0]        rx_data_q;
    logic [31:0]       shadow_q;
    logic [TMR_W-1:0]  timer_q;

    logic              accept_c;
    logic [1:0]        lane_c;
    logic [ADDR_W-1:0] addr_c;
    logic [31:0]       word_c;
    logic [BC_W-1:0]   count_inc_c;

    // Edge detect on the registered rx_valid level so a held level accepts once.
    assign accept_c    = rx_valid_q & ~rx_valid_qq;
    assign lane_c      = byte_count[1:0];
    assign addr_c      = byte_count[ADDR_W+1:2];
    assign count_inc_c = byte_count + BC_W'(1);

    // Current shadow with the incoming byte merged into its lane.
    always_comb begin
        word_c = shadow_q;
        case (lane_c)
            2'd0:    word_c[7:0]   = rx_data_q;
            2'd1:    word_c[15:8]  = rx_data_q;
            2'd2:    word_c[23:16] = rx_data_q;
            default: word_c[31:24] = rx_data_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rx_valid_q  <= 1'b0;
            rx_valid_qq <= 1'b0;
            rx_data_q   <= 8'h00;
            shadow_q    <= 32'h0;
            timer_q     <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= 32'h0;
            byte_count  <= '0;
            full        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            rx_valid_q  <= rx_valid;
            rx_valid_qq <= rx_valid_q;
            rx_data_q   <= rx_data;
            wr_en       <= 1'b0;

            if (!enable) begin
                // Disable discards any partial word; no flush.
                state_q    <= ST_IDLE;
                shadow_q   <= 32'h0;
                timer_q    <= '0;
                byte_count <= '0;
                full       <= 1'b0;
                overflow   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (accept_c) begin
                            wr_en      <= 1'b1;
                            wr_addr    <= addr_c;
                            wr_data    <= word_c;
                            byte_count <= count_inc_c;
                            timer_q    <= '0;
                            shadow_q   <= (lane_c == 2'd3) ? 32'h0 : word_c;
                            if (count_inc_c == CAPACITY) begin
                                full    <= 1'b1;
                                state_q <= ST_FULL;
                            end
                        end else if (timer_q != TMR_DONE) begin
                            // Timer saturates at the timeout so the flush fires once.
                            timer_q <= timer_q + TMR_W'(1);
                            if (timer_q == TMR_LAST && lane_c != 2'd0) begin
                                wr_en   <= 1'b1;
                                wr_addr <= addr_c;
                                wr_data <= shadow_q;
                            end
                        end
                    end
                    ST_FULL: begin
                        if (accept_c) begin
                            overflow <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Directed bench for uart_rx_word_packer with a 16-byte buffer and a short idle timeout.
module tb_uart_rx_word_packer;

    localparam int unsigned AW  = 2;
    localparam int unsigned TMO = 200;

    logic          clk;
    logic          rst;
    logic          enable;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [AW+2:0] byte_count;
    logic          full;
    logic          overflow;

    int pass_cnt  = 0;
    int total_cnt = 0;

    uart_rx_word_packer #(.ADDR_W(AW), .IDLE_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .byte_count (byte_count),
        .full       (full),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one rx_valid pulse; report write strobes seen and the last write payload.
    task automatic send_byte(input logic [7:0] b, output int pulses,
                             output logic [AW-1:0] a, output logic [31:0] d);
        pulses  = 0;
        a       = '0;
        d       = 32'h0;
        rx_data = b;
        rx_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (wr_en === 1'b1) begin
                pulses++;
                a = wr_addr;
                d = wr_data;
            end
        end
        rx_valid = 1'b0;
        @(negedge clk);
        if (wr_en === 1'b1) pulses++;
    endtask

    task automatic re_enable();
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        total_cnt++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", wr_en); else pass_cnt++;
        total_cnt++; if (wr_addr !== '0) $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); else pass_cnt++;
        total_cnt++; if (wr_data !== 32'h0) $display("FAIL reset_wr_data: got %h want 0", wr_data); else pass_cnt++;
        total_cnt++; if (byte_count !== '0) $display("FAIL reset_byte_count: got %0d want 0", byte_count); else pass_cnt++;
        total_cnt++; if ({full, overflow} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {full, overflow}); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int p; logic [AW-1:0] a; logic [31:0] d;
        logic [31:0] expw = 32'h0;
        logic [7:0] b;
        enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            b = 8'(8'h41 + i);
            expw[8*i +: 8] = b;
            send_byte(b, p, a, d);
            total_cnt++;
            if (p !== 1 || a !== AW'(0) || d !== expw)
                $display("FAIL basic_byte%0d: got pulses=%0d addr=%0d data=%h want 1/0/%h", i, p, a, d, expw);
            else pass_cnt++;
        end
        total_cnt++; if (byte_count !== 5'd4) $display("FAIL basic_count: got %0d want 4", byte_count); else pass_cnt++;
        send_byte(8'h45, p, a, d);
        total_cnt++;
        if (p !== 1 || a !== AW'(1) || d !== 32'h0000_0045)
            $display("FAIL basic_next_word: got pulses=%0d addr=%0d data=%h want 1/1/00000045", p, a, d);
        else pass_cnt++;
        total_cnt++; if (byte_count !== 5'd5) $display("FAIL basic_count5: got %0d want 5", byte_count); else pass_cnt++;
    endtask

    task automatic test_flush();
        int p; logic [AW-1:0] a; logic [31:0] d;
        int n = 0;
        re_enable();
        send_byte(8'h55, p, a, d);
        for (int i = 0; i < TMO + 2; i++) begin
            @(negedge clk);
            if (wr_en === 1'b1) begin n++; a = wr_addr; d = wr_data; end
        end
        total_cnt++;
        if (n !== 1 || a !== AW'(0) || d !== 32'h0000_0055)
            $display("FAIL flush_once: got pulses=%0d addr=%0d data=%h want 1/0/00000055", n, a, d);
        else pass_cnt++;
        n = 0;
        for (int i = 0; i < TMO + 20; i++) begin
            @(negedge clk);
            if (wr_en === 1'b1) n++;
        end
        total_cnt++; if (n !== 0) $display("FAIL flush_no_repeat: got %0d pulses want 0", n); else pass_cnt++;
        send_byte(8'h66, p, a, d);
        total_cnt++;
        if (p !== 1 || a !== AW'(0) || d !== 32'h0000_6655)
            $display("FAIL flush_then_byte: got pulses=%0d addr=%0d data=%h want 1/0/00006655", p, a, d);
        else pass_cnt++;
    endtask

    task automatic test_hold();
        int n = 0;
        re_enable();
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wr_en === 1'b1) n++;
        end
        rx_valid = 1'b0;
        @(negedge clk);
        total_cnt++; if (n !== 1) $display("FAIL hold_pulses: got %0d want 1", n); else pass_cnt++;
        total_cnt++; if (byte_count !== 5'd1) $display("FAIL hold_count: got %0d want 1", byte_count); else pass_cnt++;
    endtask

    task automatic test_timeout_edge();
        int p; logic [AW-1:0] a; logic [31:0] d;
        int n = 0;
        int at = -1;
        re_enable();
        send_byte(8'h31, p, a, d);
        repeat (TMO - 3) @(negedge clk);
        rx_data  = 8'h32;
        rx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (wr_en === 1'b1) begin n++; at = i; d = wr_data; end
        end
        rx_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (n !== 1 || at !== 1 || d !== 32'h0000_3231)
            $display("FAIL timeout_edge: got pulses=%0d slot=%0d data=%h want 1/1/00003231", n, at, d);
        else pass_cnt++;
    endtask

    task automatic test_full();
        int p; logic [AW-1:0] a; logic [31:0] d;
        logic [31:0] expw = 32'h0;
        logic [7:0] b;
        int bad = 0;
        re_enable();
        for (int i = 0; i < 16; i++) begin
            b = 8'(8'h10 + i);
            expw[8*(i%4) +: 8] = b;
            send_byte(b, p, a, d);
            if (p !== 1 || a !== AW'(i/4) || d !== expw) begin
                bad++;
                $display("FAIL full_byte%0d: got pulses=%0d addr=%0d data=%h want 1/%0d/%h", i, p, a, d, i/4, expw);
            end
            if (i == 14) begin
                total_cnt++; if (full !== 1'b0) $display("FAIL full_early: got %b want 0", full); else pass_cnt++;
            end
            if (i % 4 == 3) expw = 32'h0;
        end
        total_cnt++; if (bad != 0) $display("FAIL full_writes: %0d bad writes want 0", bad); else pass_cnt++;
        total_cnt++;
        if (full !== 1'b1 || byte_count !== 5'd16 || overflow !== 1'b0)
            $display("FAIL full_reached: got full=%b count=%0d ovf=%b want 1/16/0", full, byte_count, overflow);
        else pass_cnt++;
        send_byte(8'h99, p, a, d);
        total_cnt++; if (p !== 0) $display("FAIL overflow_write: got %0d pulses want 0", p); else pass_cnt++;
        total_cnt++;
        if (overflow !== 1'b1 || byte_count !== 5'd16 || full !== 1'b1)
            $display("FAIL overflow_state: got ovf=%b count=%0d full=%b want 1/16/1", overflow, byte_count, full);
        else pass_cnt++;
    endtask

    task automatic test_disable();
        int p; logic [AW-1:0] a; logic [31:0] d;
        re_enable();
        total_cnt++;
        if (overflow !== 1'b0 || full !== 1'b0 || byte_count !== '0)
            $display("FAIL disable_clear: got ovf=%b full=%b count=%0d want 0/0/0", overflow, full, byte_count);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) send_byte(8'(8'hC0 + i), p, a, d);
        re_enable();
        send_byte(8'hAA, p, a, d);
        total_cnt++;
        if (p !== 1 || a !== AW'(0) || d !== 32'h0000_00AA || byte_count !== 5'd1 || overflow !== 1'b0)
            $display("FAIL disable_midword: got pulses=%0d addr=%0d data=%h count=%0d want 1/0/000000aa/1", p, a, d, byte_count);
        else pass_cnt++;
    endtask

    task automatic test_rst_midword();
        int p; logic [AW-1:0] a; logic [31:0] d;
        for (int i = 0; i < 5; i++) send_byte(8'(8'hD0 + i), p, a, d);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if (byte_count !== '0 || wr_data !== 32'h0 || wr_en !== 1'b0)
            $display("FAIL rst_clear: got count=%0d data=%h wr_en=%b want 0/0/0", byte_count, wr_data, wr_en);
        else pass_cnt++;
        @(negedge clk);
        send_byte(8'hAA, p, a, d);
        total_cnt++;
        if (p !== 1 || a !== AW'(0) || d !== 32'h0000_00AA || byte_count !== 5'd1)
            $display("FAIL rst_midword: got pulses=%0d addr=%0d data=%h count=%0d want 1/0/000000aa/1", p, a, d, byte_count);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flush();
        test_hold();
        test_timeout_edge();
        test_full();
        test_disable();
        test_rst_midword();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
